// File: rtl/ps2_mouse_pkg.sv
// Shared constants and state encoding for the PS/2 mouse controller.
package ps2_mouse_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_EN_RPT   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_DEV_ID   = 8'h00;

  // Byte-0 bit positions of a stream-mode movement packet.
  localparam int unsigned PKT_BTN_MSB = 2;
  localparam int unsigned PKT_SYNC    = 3;
  localparam int unsigned PKT_XS      = 4;
  localparam int unsigned PKT_YS      = 5;
  localparam int unsigned PKT_XOV     = 6;
  localparam int unsigned PKT_YOV     = 7;

  typedef enum logic [3:0] {
    ST_SEND_RST,
    ST_WAIT_ACK1,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_SEND_EN,
    ST_WAIT_ACK2,
    ST_PKT0,
    ST_PKT1,
    ST_PKT2,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/ps2_mouse_cursor.sv
// Clamped cursor accumulator; screen y grows downward, so PS/2 dy is subtracted.
module ps2_mouse_cursor
  import ps2_mouse_pkg::*;
#(
  parameter int XY_W  = 10,
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pkt_valid_i,
  input  logic [8:0]      dx_i,
  input  logic [8:0]      dy_i,
  output logic [XY_W-1:0] cursor_x_o,
  output logic [XY_W-1:0] cursor_y_o
);

  localparam int SW = XY_W + 2;
  typedef logic signed [SW-1:0] sxy_t;

  logic [XY_W-1:0] cx_q, cy_q, cx_d, cy_d;
  sxy_t            x_sum, y_sum;

  function automatic logic [XY_W-1:0] clamp(input sxy_t v, input int max_v);
    if (v[SW-1]) return '0;
    if (v > sxy_t'(max_v)) return XY_W'(max_v);
    return v[XY_W-1:0];
  endfunction

  always_comb begin
    x_sum = sxy_t'(signed'({2'b00, cx_q})) + sxy_t'(signed'(dx_i));
    y_sum = sxy_t'(signed'({2'b00, cy_q})) - sxy_t'(signed'(dy_i));
    cx_d  = pkt_valid_i ? clamp(x_sum, X_MAX) : cx_q;
    cy_d  = pkt_valid_i ? clamp(y_sum, Y_MAX) : cy_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx_q <= XY_W'(X_MAX / 2);
      cy_q <= XY_W'(Y_MAX / 2);
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cursor_x_o = cx_q;
  assign cursor_y_o = cy_q;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse bring-up sequencer and stream-mode packet decoder.
//   state      | meaning
//   SEND_RST   | strobe 0xFF once transceiver idle, wait tx_done
//   WAIT_ACK1  | expect 0xFA (0xFE -> resend reset)
//   WAIT_BAT   | expect 0xAA (0xFC -> failed attempt)
//   WAIT_ID    | expect device id 0x00
//   SEND_EN    | strobe 0xF4, wait tx_done
//   WAIT_ACK2  | expect 0xFA (0xFE -> resend enable)
//   PKT0..2    | collect movement packet bytes
//   ERROR      | init gave up; only reset leaves
module ps2_mouse_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int TIMEOUT_W = 24,
  parameter int MAX_RETRY = 3,
  parameter int XY_W      = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ps2_wr_stb,
  output logic [7:0]      ps2_wr_data,
  input  logic            ps2_tx_done,
  input  logic            ps2_tx_ready,
  input  logic            ps2_rddata_valid,
  input  logic [7:0]      ps2_rd_data,
  output logic            mouse_ready,
  output logic            init_err,
  output logic            pkt_valid,
  output logic [2:0]      btn,
  output logic [8:0]      dx,
  output logic [8:0]      dy,
  output logic [XY_W-1:0] cursor_x,
  output logic [XY_W-1:0] cursor_y
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_e               state_q;
  logic                 sent_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [TIMEOUT_W-1:0] tmr_q;
  logic                 wr_stb_q;
  logic [7:0]           wr_data_q;
  logic                 ready_q, err_q, pkt_valid_q;
  logic [7:0]           b0_q, b1_q;
  logic [2:0]           btn_q;
  logic [8:0]           dx_q, dy_q;

  logic       timeout, in_init, bat_fail, init_fail, pkt_fire;
  logic [8:0] dx_new, dy_new;

  assign timeout   = (tmr_q == '0) && !ps2_rddata_valid;
  assign in_init   = state_q inside {ST_SEND_RST, ST_WAIT_ACK1, ST_WAIT_BAT,
                                     ST_WAIT_ID, ST_SEND_EN, ST_WAIT_ACK2};
  assign bat_fail  = (state_q == ST_WAIT_BAT) && ps2_rddata_valid &&
                     (ps2_rd_data == RSP_BAT_FAIL);
  assign init_fail = in_init && (timeout || bat_fail);
  assign pkt_fire  = (state_q == ST_PKT2) && ps2_rddata_valid;

  // Overflowed axes report zero movement rather than a wrapped value.
  assign dx_new = b0_q[PKT_XOV] ? 9'd0 : {b0_q[PKT_XS], b1_q};
  assign dy_new = b0_q[PKT_YOV] ? 9'd0 : {b0_q[PKT_YS], ps2_rd_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SEND_RST;
      sent_q      <= 1'b0;
      retry_q     <= '0;
      tmr_q       <= '1;
      wr_stb_q    <= 1'b0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      pkt_valid_q <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      btn_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
    end else begin
      wr_stb_q    <= 1'b0;
      pkt_valid_q <= 1'b0;
      if (ps2_rddata_valid) tmr_q <= '1;
      else if (tmr_q != '0) tmr_q <= tmr_q - TIMEOUT_W'(1);

      if (init_fail) begin
        retry_q <= retry_q + RETRY_W'(1);
        sent_q  <= 1'b0;
        tmr_q   <= '1;
        if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
          state_q <= ST_ERROR;
          err_q   <= 1'b1;
        end else begin
          state_q <= ST_SEND_RST;
        end
      end else begin
        case (state_q)
          ST_SEND_RST, ST_SEND_EN: begin
            if (!sent_q) begin
              if (ps2_tx_ready) begin
                wr_stb_q  <= 1'b1;
                wr_data_q <= (state_q == ST_SEND_RST) ? CMD_RESET : CMD_EN_RPT;
                sent_q    <= 1'b1;
              end
            end else if (ps2_tx_done) begin
              sent_q  <= 1'b0;
              tmr_q   <= '1;
              state_q <= (state_q == ST_SEND_RST) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
            end
          end
          ST_WAIT_ACK1: begin
            if (ps2_rddata_valid && ps2_rd_data == RSP_ACK) begin
              state_q <= ST_WAIT_BAT;
            end else if (ps2_rddata_valid && ps2_rd_data == RSP_RESEND) begin
              state_q <= ST_SEND_RST;
            end
          end
          ST_WAIT_BAT: begin
            if (ps2_rddata_valid && ps2_rd_data == RSP_BAT_OK) state_q <= ST_WAIT_ID;
          end
          ST_WAIT_ID: begin
            if (ps2_rddata_valid && ps2_rd_data == RSP_DEV_ID) state_q <= ST_SEND_EN;
          end
          ST_WAIT_ACK2: begin
            if (ps2_rddata_valid && ps2_rd_data == RSP_ACK) begin
              state_q <= ST_PKT0;
              ready_q <= 1'b1;
            end else if (ps2_rddata_valid && ps2_rd_data == RSP_RESEND) begin
              state_q <= ST_SEND_EN;
            end
          end
          ST_PKT0: begin
            if (ps2_rddata_valid && ps2_rd_data[PKT_SYNC]) begin
              b0_q    <= ps2_rd_data;
              state_q <= ST_PKT1;
            end
          end
          ST_PKT1: begin
            if (ps2_rddata_valid) begin
              b1_q    <= ps2_rd_data;
              state_q <= ST_PKT2;
            end else if (timeout) begin
              state_q <= ST_PKT0;
              tmr_q   <= '1;
            end
          end
          ST_PKT2: begin
            if (pkt_fire) begin
              btn_q       <= b0_q[PKT_BTN_MSB:0];
              dx_q        <= dx_new;
              dy_q        <= dy_new;
              pkt_valid_q <= 1'b1;
              state_q     <= ST_PKT0;
            end else if (timeout) begin
              state_q <= ST_PKT0;
              tmr_q   <= '1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ps2_mouse_cursor #(
    .XY_W  (XY_W),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .pkt_valid_i (pkt_fire),
    .dx_i        (dx_new),
    .dy_i        (dy_new),
    .cursor_x_o  (cursor_x),
    .cursor_y_o  (cursor_y)
  );

  assign ps2_wr_stb  = wr_stb_q;
  assign ps2_wr_data = wr_data_q;
  assign mouse_ready = ready_q;
  assign init_err    = err_q;
  assign pkt_valid   = pkt_valid_q;
  assign btn         = btn_q;
  assign dx          = dx_q;
  assign dy          = dy_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench: transceiver model, init sequences, packet vector table, corner cases.
module tb_ps2_mouse_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_wr_stb;
  logic [7:0] ps2_wr_data;
  logic       ps2_tx_done = 1'b0;
  logic       ps2_tx_ready = 1'b1;
  logic       ps2_rddata_valid = 1'b0;
  logic [7:0] ps2_rd_data = 8'h00;
  logic       mouse_ready, init_err, pkt_valid;
  logic [2:0] btn;
  logic [8:0] dx, dy;
  logic [9:0] cursor_x, cursor_y;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_stb = 0;
  int   proto_err = 0;
  int   busy_cnt = 0;
  bit   busy = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] cmd_hist [64];

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    int         cx, cy;
  } vec_t;
  vec_t vecs [21];

  always #5 clk = ~clk;

  ps2_mouse_ctrl #(.TIMEOUT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .ps2_wr_stb       (ps2_wr_stb),
    .ps2_wr_data      (ps2_wr_data),
    .ps2_tx_done      (ps2_tx_done),
    .ps2_tx_ready     (ps2_tx_ready),
    .ps2_rddata_valid (ps2_rddata_valid),
    .ps2_rd_data      (ps2_rd_data),
    .mouse_ready      (mouse_ready),
    .init_err         (init_err),
    .pkt_valid        (pkt_valid),
    .btn              (btn),
    .dx               (dx),
    .dy               (dy),
    .cursor_x         (cursor_x),
    .cursor_y         (cursor_y)
  );

  // Transceiver model: busy for a few cycles after each strobe, then pulses tx_done.
  always @(negedge clk) begin
    ps2_tx_done = 1'b0;
    if (!rst) begin
      busy         = 1'b0;
      ps2_tx_ready = 1'b1;
    end else if (ps2_wr_stb) begin
      if (busy) proto_err++;
      if (n_stb < 64) cmd_hist[n_stb] = ps2_wr_data;
      n_stb++;
      busy         = 1'b1;
      busy_cnt     = 3;
      ps2_tx_ready = 1'b0;
      held         = ps2_wr_data;
    end else if (busy) begin
      if (ps2_wr_data != held) proto_err++;
      if (busy_cnt == 0) begin
        busy         = 1'b0;
        ps2_tx_done  = 1'b1;
        ps2_tx_ready = 1'b1;
      end else begin
        busy_cnt--;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    ps2_rd_data      = b;
    ps2_rddata_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    put(b);
    ps2_rddata_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx(input int target, input string nm);
    int cyc;
    cyc = 0;
    while (!(n_stb >= target && !busy) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, 32'(n_stb >= target && !busy), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_init(input bit resend);
    int base;
    base = n_stb;
    wait_tx(base + 1, "init_rst_strobe");
    chk("init_cmd_rst", 32'(cmd_hist[base]), 32'hFF);
    send(8'hFA);
    send(8'hAA);
    send(8'h00);
    chk("init_not_ready_yet", 32'(mouse_ready), 0);
    wait_tx(base + 2, "init_en_strobe");
    chk("init_cmd_en", 32'(cmd_hist[base + 1]), 32'hF4);
    if (resend) begin
      send(8'hFE);
      wait_tx(base + 3, "resend_strobe");
      chk("resend_cmd_en", 32'(cmd_hist[base + 2]), 32'hF4);
    end
    send(8'hFA);
    chk("init_ready", 32'(mouse_ready), 1);
    chk("init_strobe_count", 32'(n_stb - base), resend ? 32'd3 : 32'd2);
  endtask

  task automatic chk_pkt(input string nm, input logic [2:0] eb, input logic [8:0] edx,
                         input logic [8:0] edy, input int ecx, input int ecy);
    chk({nm, "_valid"}, 32'(pkt_valid), 1);
    chk({nm, "_btn"}, 32'(btn), 32'(eb));
    chk({nm, "_dx"}, 32'(dx), 32'(edx));
    chk({nm, "_dy"}, 32'(dy), 32'(edy));
    chk({nm, "_cx"}, 32'(cursor_x), 32'(ecx));
    chk({nm, "_cy"}, 32'(cursor_y), 32'(ecy));
  endtask

  initial begin
    int base;
    int cyc;
    vecs[0]  = '{8'h39, 8'h05, 8'hFE, 3'b001, 9'h105, 9'h1FE,  68, 241};
    vecs[1]  = '{8'h08, 8'h01, 8'h01, 3'b000, 9'h001, 9'h001,  69, 240};
    vecs[2]  = '{8'h4A, 8'h10, 8'h20, 3'b010, 9'h000, 9'h020,  69, 208};
    vecs[3]  = '{8'h8C, 8'h7F, 8'h33, 3'b100, 9'h07F, 9'h000, 196, 208};
    vecs[4]  = '{8'h08, 8'h7F, 8'h00, 3'b000, 9'h07F, 9'h000, 323, 208};
    vecs[5]  = '{8'h08, 8'h7F, 8'h00, 3'b000, 9'h07F, 9'h000, 450, 208};
    vecs[6]  = '{8'h08, 8'h7F, 8'h00, 3'b000, 9'h07F, 9'h000, 577, 208};
    vecs[7]  = '{8'h08, 8'h7F, 8'h00, 3'b000, 9'h07F, 9'h000, 639, 208};
    vecs[8]  = '{8'h08, 8'h7F, 8'h00, 3'b000, 9'h07F, 9'h000, 639, 208};
    vecs[9]  = '{8'h18, 8'h80, 8'h00, 3'b000, 9'h180, 9'h000, 511, 208};
    vecs[10] = '{8'h28, 8'h00, 8'h80, 3'b000, 9'h000, 9'h180, 511, 336};
    vecs[11] = '{8'h28, 8'h00, 8'h80, 3'b000, 9'h000, 9'h180, 511, 464};
    vecs[12] = '{8'h28, 8'h00, 8'h80, 3'b000, 9'h000, 9'h180, 511, 479};
    vecs[13] = '{8'h18, 8'h01, 8'h00, 3'b000, 9'h101, 9'h000, 256, 479};
    vecs[14] = '{8'h18, 8'h01, 8'h00, 3'b000, 9'h101, 9'h000,   1, 479};
    vecs[15] = '{8'h18, 8'h01, 8'h00, 3'b000, 9'h101, 9'h000,   0, 479};
    vecs[16] = '{8'h08, 8'h00, 8'h7F, 3'b000, 9'h000, 9'h07F,   0, 352};
    vecs[17] = '{8'h08, 8'h00, 8'h7F, 3'b000, 9'h000, 9'h07F,   0, 225};
    vecs[18] = '{8'h08, 8'h00, 8'h7F, 3'b000, 9'h000, 9'h07F,   0,  98};
    vecs[19] = '{8'h08, 8'h00, 8'h7F, 3'b000, 9'h000, 9'h07F,   0,   0};
    vecs[20] = '{8'hFF, 8'h55, 8'hAA, 3'b111, 9'h000, 9'h000,   0,   0};

    repeat (3) @(negedge clk);
    chk("rst_wr_stb",   32'(ps2_wr_stb), 0);
    chk("rst_wr_data",  32'(ps2_wr_data), 0);
    chk("rst_ready",    32'(mouse_ready), 0);
    chk("rst_init_err", 32'(init_err), 0);
    chk("rst_pkt_valid", 32'(pkt_valid), 0);
    chk("rst_btn",      32'(btn), 0);
    chk("rst_dx",       32'(dx), 0);
    chk("rst_dy",       32'(dy), 0);
    chk("rst_cursor_x", 32'(cursor_x), 319);
    chk("rst_cursor_y", 32'(cursor_y), 239);
    rst = 1'b1;
    @(negedge clk);

    do_init(1'b0);
    for (int i = 0; i < 21; i++) begin
      put(vecs[i].b0);
      put(vecs[i].b1);
      chk($sformatf("vec%0d_early", i), 32'(pkt_valid), 0);
      put(vecs[i].b2);
      ps2_rddata_valid = 1'b0;
      chk_pkt($sformatf("vec%0d", i), vecs[i].btn, vecs[i].dx, vecs[i].dy,
              vecs[i].cx, vecs[i].cy);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", i), 32'(pkt_valid), 0);
    end

    pulse_reset();
    do_init(1'b0);
    put(8'h00);
    ps2_rddata_valid = 1'b0;
    repeat (2) @(negedge clk);
    put(8'h08);
    put(8'h01);
    chk("resync_early", 32'(pkt_valid), 0);
    put(8'h01);
    chk_pkt("resync", 3'b000, 9'h001, 9'h001, 320, 238);
    put(8'h08);
    chk("b2b_pulse_end", 32'(pkt_valid), 0);
    put(8'h02);
    put(8'h02);
    ps2_rddata_valid = 1'b0;
    chk_pkt("b2b", 3'b000, 9'h002, 9'h002, 322, 236);

    put(8'h08);
    ps2_rddata_valid = 1'b0;
    repeat (300) @(negedge clk);
    put(8'h08);
    put(8'h03);
    chk("ptmo_early", 32'(pkt_valid), 0);
    put(8'h00);
    ps2_rddata_valid = 1'b0;
    chk_pkt("ptmo", 3'b000, 9'h003, 9'h000, 325, 236);

    put(8'h09);
    put(8'h05);
    ps2_rddata_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", 32'(mouse_ready), 0);
    chk("arst_cx",    32'(cursor_x), 319);
    chk("arst_cy",    32'(cursor_y), 239);
    chk("arst_btn",   32'(btn), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_init(1'b1);
    put(8'h08);
    put(8'h01);
    put(8'h01);
    ps2_rddata_valid = 1'b0;
    chk_pkt("post_resend", 3'b000, 9'h001, 9'h001, 320, 238);

    pulse_reset();
    base = n_stb;
    cyc = 0;
    while (!init_err && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("noresp_init_err", 32'(init_err), 1);
    chk("noresp_ready",    32'(mouse_ready), 0);
    chk("noresp_strobes",  32'(n_stb - base), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("noresp_cmd%0d", k), 32'(cmd_hist[base + k]), 32'hFF);
    repeat (600) @(negedge clk);
    chk("err_sticky",      32'(init_err), 1);
    chk("err_no_strobes",  32'(n_stb - base), 3);

    chk("tx_protocol", 32'(proto_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
